rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
Round-robin arbiter that shares one resource among up to 15 requesters. It selects a winner as a 4-bit binary index. It drives the matching one-hot grant through the team's binary-to-one-hot encoder (enc_bin2onehot). Each grant is held until the owner releases it or a hold-limit timeout fires. The block sits in front of the shared datapath and drives its select/enable lines.

Parameters:
NREQ, 15, number of requesters; must be at most 2**IDXW - 1.
IDXW, 4, width of the binary grant index.
MAX_HOLD, 16, maximum number of cycles a grant may be held before forced release; must be at least 2.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset.
req  input  NREQ  request vector; bit i is held high while requester i wants the resource.
done  input  1  release strobe from the current owner; sampled only while a grant is active.
gnt_valid  output  1  a grant is active.
gnt_idx  output  IDXW  binary index of the owner; 0 when gnt_valid is 0.
gnt_onehot  output  NREQ  one-hot of gnt_idx; all-zero when gnt_valid is 0.
timeout_pulse  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Clock and reset ports are named clk and rst.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Round-robin pointer ptr goes to NREQ-1, so requester 0 has first priority.
  - Hold counter goes to 0.
  - Reset mid-grant drops the grant at that same edge; no timeout_pulse is produced.
- State IDLE:
  - If any req bit is high at edge t, go to HOLD.
  - Winner = first set bit scanning ptr+1, ptr+2, ... with wrap modulo NREQ.
  - At edge t: gnt_idx = winner, gnt_valid = 1, ptr = winner, hold counter = 0.
  - Grant latency is 1 cycle from a sampled request.
- State HOLD:
  - gnt_idx and gnt_onehot stay stable; req changes from non-owners are ignored.
  - The hold counter increments every cycle.
  - Release conditions, evaluated at each edge in this priority order:
    - (a) done = 1;
    - (b) req[gnt_idx] = 0;
    - (c) counter = MAX_HOLD-1, which also sets timeout_pulse = 1 for the following cycle.
  - On release, go to IDLE and clear gnt_valid, gnt_idx and gnt_onehot.
  - If (c) coincides with (a) or (b), release without timeout_pulse.
- Gap cycle: after every release, at least one cycle has gnt_valid = 0. Re-arbitration uses req sampled in that IDLE cycle. Release at edge t gives the next grant at edge t+1 at the earliest.
- Fairness: a requester that holds req high continuously is granted within NREQ-1 other grants.
- Width rules:
  - gnt_idx is never at or above NREQ.
  - gnt_onehot[i] = gnt_valid & (gnt_idx == i) for every i in 0..NREQ-1, including i = 4 and i = 14.
- done while IDLE is ignored; req bits at or above NREQ do not exist.
- All outputs are registered; there is no combinational path from req or done to any output.

Decomposition:
- Package arb_pkg holds:
  - localparams NREQ_DEF = 15, IDXW_DEF = 4, MAX_HOLD_DEF = 16;
  - the state typedef st_e {ST_IDLE, ST_HOLD}.
- Sub-module rr_pick (combinational): inputs are req and ptr; outputs are the found flag and the winner index, using a rotate/priority scan.
- The enc_bin2onehot instance takes in = gnt_idx and in_valid = gnt_valid; its output feeds gnt_onehot.
- FSM, pointer and hold counter live in the top module.

Test Plan:
- Reset then single request: rst 1 for 2 cycles, then req = 0x0001 → gnt_valid = 1 one cycle later, gnt_idx = 0, gnt_onehot = 0x0001; done pulse → gnt_valid = 0 next cycle.
- Rotation: req = 0x7FFF held, done pulsed every 3rd cycle → gnt_idx sequence 0, 1, 2, …, 14, 0; each grant is separated by exactly one gap cycle.
- Every index: req = 1<<i for i = 0..14 in turn → gnt_idx = i and gnt_onehot = 1<<i; idx 4 must give 0x0010.
- Timeout: req = 0x0020 held, no done → after 16 cycles of grant, released; timeout_pulse = 1 for one cycle; re-granted to idx 5 after the gap; done and timeout on the same edge → no pulse.
- Requester drop and mid-grant reset:
  - owner 3 drops req → release next edge with no pulse.
  - rst asserted during a grant to idx 9 → all outputs 0 at the next edge; req = 0x0201 afterwards → idx 0 granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and state encoding for the round-robin one-hot arbiter.
package arb_pkg;

   localparam int NREQ_DEF     = 15;
   localparam int IDXW_DEF     = 4;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } st_e;

endpackage

// File: rtl/enc_bin2onehot.sv
// Binary index to one-hot decoder with a qualifying valid.
module enc_bin2onehot #(
   parameter int N = 15,
   parameter int W = 4
) (
   input  logic [W-1:0] in,
   input  logic         in_valid,
   output logic [N-1:0] out
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign out[i] = in_valid && (in == W'(i));
   end

endmodule

// File: rtl/rr_pick.sv
// Rotating priority scan: first set request after ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 15,
   parameter int IDXW = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            found,
   output logic [IDXW-1:0] idx
);

   logic [2**IDXW-1:0] reqp;
   logic [IDXW:0]      j;

   always_comb begin
      reqp = '0;
      reqp[NREQ-1:0] = req;
      found = 1'b0;
      idx = '0;
      j = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = {1'b0, ptr} + (IDXW+1)'(k);
         if (j >= (IDXW+1)'(NREQ))
            j = j - (IDXW+1)'(NREQ);
         if (!found && reqp[j[IDXW-1:0]]) begin
            found = 1'b1;
            idx = j[IDXW-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with hold-until-release grants and a hold-limit timeout.
module rr_onehot_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int IDXW     = IDXW_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx,
   output logic [NREQ-1:0] gnt_onehot,
   output logic            timeout_pulse
);

   localparam int CW = $clog2(MAX_HOLD);

   st_e                st;
   logic [IDXW-1:0]    ptr;
   logic [CW-1:0]      cnt;
   logic               found;
   logic [IDXW-1:0]    win;
   logic [2**IDXW-1:0] reqp;
   logic               req_own;
   logic               expire;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (found),
      .idx   (win)
   );

   enc_bin2onehot #(
      .N (NREQ),
      .W (IDXW)
   ) u_enc (
      .in       (gnt_idx),
      .in_valid (gnt_valid),
      .out      (gnt_onehot)
   );

   always_comb begin
      reqp = '0;
      reqp[NREQ-1:0] = req;
      req_own = reqp[gnt_idx];
      expire = (cnt == CW'(MAX_HOLD - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= ST_IDLE;
         ptr           <= IDXW'(NREQ - 1);
         cnt           <= '0;
         gnt_valid     <= 1'b0;
         gnt_idx       <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         unique case (st)
            ST_IDLE: begin
               if (found) begin
                  st        <= ST_HOLD;
                  gnt_valid <= 1'b1;
                  gnt_idx   <= win;
                  ptr       <= win;
                  cnt       <= '0;
               end
            end
            ST_HOLD: begin
               cnt <= cnt + CW'(1);
               // Owner release outranks the timeout, which then stays silent.
               if (done || !req_own || expire) begin
                  st            <= ST_IDLE;
                  gnt_valid     <= 1'b0;
                  gnt_idx       <= '0;
                  cnt           <= '0;
                  timeout_pulse <= expire && !done && req_own;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: per-cycle expectations queued at drive time.
module tb_rr_onehot_arbiter;

   typedef struct {
      logic       v;
      logic [3:0] idx;
      logic       to;
      string      tag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [14:0] req;
   logic        done;
   logic        gnt_valid;
   logic [3:0]  gnt_idx;
   logic [14:0] gnt_onehot;
   logic        timeout_pulse;

   exp_t q[$];
   int   n_chk;
   int   n_pass;

   rr_onehot_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .done          (done),
      .gnt_valid     (gnt_valid),
      .gnt_idx       (gnt_idx),
      .gnt_onehot    (gnt_onehot),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      n_chk++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
   endtask

   task automatic cyc(logic [14:0] r, logic d, logic rs,
                      logic ev, int ei, logic et, string tag);
      exp_t e;
      @(negedge clk);
      req  = r;
      done = d;
      rst  = rs;
      e.v   = ev;
      e.idx = 4'(ei);
      e.to  = et;
      e.tag = tag;
      q.push_back(e);
   endtask

   always begin
      exp_t        e;
      logic [14:0] oh;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e  = q.pop_front();
         oh = '0;
         if (e.v) oh[e.idx] = 1'b1;
         chk({e.tag, ".valid"}, 32'(gnt_valid), 32'(e.v));
         chk({e.tag, ".idx"}, 32'(gnt_idx), 32'(e.idx));
         chk({e.tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
         chk({e.tag, ".pulse"}, 32'(timeout_pulse), 32'(e.to));
      end
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      req    = '0;
      done   = 1'b0;

      cyc(15'h0000, 0, 1, 0, 0, 0, "rst0");
      cyc(15'h0000, 0, 1, 0, 0, 0, "rst1");
      cyc(15'h0001, 0, 0, 1, 0, 0, "single_gnt");
      cyc(15'h0001, 1, 0, 0, 0, 0, "single_done");
      cyc(15'h0000, 1, 0, 0, 0, 0, "idle_done");

      cyc(15'h0000, 0, 1, 0, 0, 0, "rst2");
      cyc(15'h0000, 0, 1, 0, 0, 0, "rst3");
      for (int g = 0; g < 16; g++) begin
         cyc(15'h7FFF, 0, 0, 1, g % 15, 0, $sformatf("rot%0d_a", g));
         cyc(15'h7FFF, 0, 0, 1, g % 15, 0, $sformatf("rot%0d_b", g));
         cyc(15'h7FFF, 1, 0, 0, 0, 0, $sformatf("rot%0d_gap", g));
      end

      for (int i = 0; i < 15; i++) begin
         cyc(15'(1 << i), 0, 0, 1, i, 0, $sformatf("idx%0d", i));
         cyc(15'(1 << i), 1, 0, 0, 0, 0, $sformatf("idx%0d_rel", i));
      end

      cyc(15'h0020, 0, 0, 1, 5, 0, "to_gnt");
      for (int k = 0; k < 15; k++)
         cyc(15'h0020, 0, 0, 1, 5, 0, $sformatf("to_hold%0d", k));
      cyc(15'h0020, 0, 0, 0, 0, 1, "to_fire");
      cyc(15'h0020, 0, 0, 1, 5, 0, "to_regnt");
      for (int k = 0; k < 15; k++)
         cyc(15'h0020, 0, 0, 1, 5, 0, $sformatf("to2_hold%0d", k));
      cyc(15'h0020, 1, 0, 0, 0, 0, "to_done_tie");
      cyc(15'h0000, 0, 0, 0, 0, 0, "to_idle");

      cyc(15'h0008, 0, 0, 1, 3, 0, "drop_gnt");
      cyc(15'h0008, 0, 0, 1, 3, 0, "drop_hold");
      cyc(15'h0000, 0, 0, 0, 0, 0, "drop_rel");
      cyc(15'h0200, 0, 0, 1, 9, 0, "mr_gnt");
      cyc(15'h0200, 0, 1, 0, 0, 0, "mr_rst");
      cyc(15'h0201, 0, 0, 1, 0, 0, "mr_first0");
      cyc(15'h0201, 1, 0, 0, 0, 0, "mr_rel");
      cyc(15'h0201, 0, 0, 1, 9, 0, "mr_next9");
      cyc(15'h0201, 1, 0, 0, 0, 0, "mr_rel2");

      for (int k = 0; k < 5 && q.size() > 0; k++)
         @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
